frame_rx_checker: RTL and testbench

//  Receive-side counterpart of the nibble frame transmitter: consumes the 4-bit data/valid stream, locks on preamble+SFD,

---
 rtl/frame_rx_checker.sv | 192 +++++++++++++++++++
 tb/tb_frame_rx_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rx_checker.sv
// Nibble-stream Ethernet/IP/UDP frame receiver: preamble/SFD lock, header capture,
// CRC-32 FCS check, per-frame status pulse with held error flags and saturating counters.

module crc32_4bit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        data_valid,
  input  logic [3:0]  data,
  output logic [31:0] crc_out
);
  logic [31:0] crc_q;
  logic [31:0] crc_nxt;

  // Reflected CRC-32, data bits consumed LSB first (low nibble of a byte goes in first)
  always_comb begin
    crc_nxt = crc_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (crc_nxt[0] ^ data[i]) crc_nxt = (crc_nxt >> 1) ^ 32'hEDB88320;
      else                      crc_nxt = crc_nxt >> 1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        crc_q <= '1;
    else if (clear)      crc_q <= '1;
    else if (data_valid) crc_q <= crc_nxt;
  end

  assign crc_out = ~crc_q;
endmodule

module frame_rx_checker #(
  parameter logic [47:0] MY_MAC  = 48'hAABBCCDDEEFF,
  parameter logic [15:0] ETYPE   = 16'h0800,
  parameter int unsigned MIN_PRE = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       rx_data,
  input  logic             rx_valid,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             crc_err,
  output logic             mac_err,
  output logic             type_err,
  output logic             len_err,
  output logic [47:0]      src_mac,
  output logic [159:0]     ip_header,
  output logic [63:0]      udp_header,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);
  typedef enum logic [2:0] {IDLE, PRE, HDR, FCS, END, CHECK, DROP} state_t;

  localparam logic [3:0] MIN_PRE_N = 4'(MIN_PRE);

  state_t       state;
  logic [3:0]   pre_cnt;
  logic [6:0]   cnt;
  logic [3:0]   lo_nib;
  logic [335:0] hdr_sr;
  logic [31:0]  fcs_rx;
  logic         len_flag;

  logic         crc_clear;
  logic         crc_valid;
  logic [31:0]  crc_out;
  logic         chk_crc;
  logic         chk_mac;
  logic         chk_type;
  logic         chk_ok;

  assign crc_clear = (state == IDLE) || (state == PRE);
  assign crc_valid = (state == HDR) && rx_valid;

  crc32_4bit u_crc (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (crc_clear),
    .data_valid (crc_valid),
    .data       (rx_data),
    .crc_out    (crc_out)
  );

  // hdr_sr holds whole bytes, first received byte ends up in [335:328]
  assign chk_crc  = (crc_out != fcs_rx);
  assign chk_mac  = (hdr_sr[335:288] != MY_MAC) && (hdr_sr[335:288] != '1);
  assign chk_type = (hdr_sr[239:224] != ETYPE);
  assign chk_ok   = ~(chk_crc | chk_mac | chk_type | len_flag);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      cnt        <= '0;
      lo_nib     <= '0;
      hdr_sr     <= '0;
      fcs_rx     <= '0;
      len_flag   <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      crc_err    <= 1'b0;
      mac_err    <= 1'b0;
      type_err   <= 1'b0;
      len_err    <= 1'b0;
      src_mac    <= '0;
      ip_header  <= '0;
      udp_header <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && rx_data == 4'h5) begin
            state   <= PRE;
            pre_cnt <= 4'd1;
          end
        end
        PRE: begin
          if (!rx_valid) begin
            state <= IDLE;
          end else if (rx_data == 4'h5) begin
            if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
          end else if (rx_data == 4'hD && pre_cnt >= MIN_PRE_N) begin
            state    <= HDR;
            cnt      <= '0;
            len_flag <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        HDR: begin
          if (!rx_valid) begin
            len_flag <= 1'b1;
            state    <= CHECK;
          end else begin
            if (!cnt[0]) lo_nib <= rx_data;
            else         hdr_sr <= {hdr_sr[327:0], rx_data, lo_nib};
            if (cnt == 7'd83) begin
              state <= FCS;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        FCS: begin
          if (!rx_valid) begin
            len_flag <= 1'b1;
            state    <= CHECK;
          end else begin
            fcs_rx[{cnt[2:0], 2'b00} +: 4] <= rx_data;
            if (cnt == 7'd7) state <= END;
            else             cnt   <= cnt + 7'd1;
          end
        end
        END: begin
          if (rx_valid) begin
            len_flag <= 1'b1;
            state    <= DROP;
          end else begin
            state <= CHECK;
          end
        end
        DROP: begin
          if (!rx_valid) state <= CHECK;
        end
        CHECK: begin
          frame_done <= 1'b1;
          frame_ok   <= chk_ok;
          crc_err    <= chk_crc;
          mac_err    <= chk_mac;
          type_err   <= chk_type;
          len_err    <= len_flag;
          if (chk_ok) begin
            src_mac    <= hdr_sr[287:240];
            ip_header  <= hdr_sr[223:64];
            udp_header <= hdr_sr[63:0];
            if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
          end else begin
            if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_rx_checker.sv
// Directed bench for frame_rx_checker: table of frame vectors plus reset/latency sequences.

module tb_frame_rx_checker;
  localparam logic [159:0] IP_HDR = 160'h4500_0030_1234_4000_4011_0000_C0A8_0001_C0A8_0002;

  logic         clock;
  logic         reset_n;
  logic [3:0]   rx_data;
  logic         rx_valid;
  logic         frame_done;
  logic         frame_ok;
  logic         crc_err;
  logic         mac_err;
  logic         type_err;
  logic         len_err;
  logic [47:0]  src_mac;
  logic [159:0] ip_header;
  logic [63:0]  udp_header;
  logic [15:0]  good_cnt;
  logic [15:0]  bad_cnt;

  frame_rx_checker #(
    .MY_MAC  (48'hAABBCCDDEEFF),
    .ETYPE   (16'h0800),
    .MIN_PRE (4),
    .CNT_W   (16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .crc_err    (crc_err),
    .mac_err    (mac_err),
    .type_err   (type_err),
    .len_err    (len_err),
    .src_mac    (src_mac),
    .ip_header  (ip_header),
    .udp_header (udp_header),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    logic [63:0] udp;
    int          pre_len;
    int          n_send;    // nibbles after SFD: 92 is a proper frame
    int          flip;      // header nibble to corrupt, -1 for none
    bit          exp_done;
    bit          e_crc;
    bit          e_mac;
    bit          e_type;
    bit          e_len;
    bit          chk_errs;  // compare crc/mac/type flags too
  } vec_t;

  vec_t vecs[10];

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  int           exp_good = 0;
  int           exp_bad = 0;
  logic [47:0]  last_src = '0;
  logic [159:0] last_ip = '0;
  logic [63:0]  last_udp = '0;

  always @(negedge clock) if (frame_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d);
    @(negedge clock);
    rx_valid = v;
    rx_data  = d;
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [335:0] hb;
    logic [7:0]   by;
    logic [31:0]  crc;
    logic [3:0]   nibs[93];
    bit           exp_ok;
    bit           seen;
    int           lat;
    int           start;

    hb  = {v.dest, v.src, v.etype, IP_HDR, v.udp};
    crc = 32'hFFFF_FFFF;
    for (int b = 0; b < 42; b++) begin
      by = hb[335 - 8*b -: 8];
      nibs[2*b]     = by[3:0];
      nibs[2*b + 1] = by[7:4];
      crc = crc ^ {24'd0, by};
      for (int k = 0; k < 8; k++)
        crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    for (int k = 0; k < 8; k++) nibs[84 + k] = crc[4*k +: 4];
    nibs[92] = 4'h7;
    if (v.flip >= 0) nibs[v.flip] = nibs[v.flip] ^ 4'h1;

    start = done_cnt;
    for (int i = 0; i < v.pre_len; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < v.n_send; i++) drive(1'b1, nibs[i]);
    drive(1'b0, 4'h0);

    exp_ok = !(v.e_crc || v.e_mac || v.e_type || v.e_len);
    if (v.exp_done) begin
      seen = 1'b0;
      lat  = 0;
      for (int t = 0; t < 12 && !seen; t++) begin
        @(negedge clock);
        lat++;
        seen = frame_done;
      end
      chk({tag, " done_seen"}, 160'(seen), 160'(1));
      chk({tag, " latency"}, 160'(lat), 160'(2));
      if (exp_ok) begin
        exp_good++;
        last_src = v.src;
        last_ip  = IP_HDR;
        last_udp = v.udp;
      end else begin
        exp_bad++;
      end
      chk({tag, " frame_ok"}, 160'(frame_ok), 160'(exp_ok));
      chk({tag, " len_err"}, 160'(len_err), 160'(v.e_len));
      if (v.chk_errs) begin
        chk({tag, " crc_err"}, 160'(crc_err), 160'(v.e_crc));
        chk({tag, " mac_err"}, 160'(mac_err), 160'(v.e_mac));
        chk({tag, " type_err"}, 160'(type_err), 160'(v.e_type));
      end
      chk({tag, " good_cnt"}, 160'(good_cnt), 160'(exp_good));
      chk({tag, " bad_cnt"}, 160'(bad_cnt), 160'(exp_bad));
      chk({tag, " src_mac"}, 160'(src_mac), 160'(last_src));
      chk({tag, " ip_header"}, ip_header, last_ip);
      chk({tag, " udp_header"}, 160'(udp_header), 160'(last_udp));
      @(negedge clock);
      chk({tag, " done_pulse_end"}, 160'(frame_done), 160'(0));
      chk({tag, " ok_held"}, 160'(frame_ok), 160'(exp_ok));
    end else begin
      repeat (10) @(negedge clock);
      chk({tag, " no_done"}, 160'(done_cnt - start), 160'(0));
      chk({tag, " good_unch"}, 160'(good_cnt), 160'(exp_good));
      chk({tag, " bad_unch"}, 160'(bad_cnt), 160'(exp_bad));
    end
  endtask

  initial begin
    vec_t base;
    base = '{48'hAABBCCDDEEFF, 48'h112233445566, 16'h0800, 64'h1F90_0035_001C_0000,
             15, 92, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    vecs[0] = base;
    vecs[1] = base; vecs[1].src = 48'h0A0B0C0D0E0F; vecs[1].flip = 40; vecs[1].e_crc = 1'b1;
    vecs[2] = base; vecs[2].dest = 48'h010203040506; vecs[2].src = 48'h0A0B0C0D0E0F; vecs[2].e_mac = 1'b1;
    vecs[3] = base; vecs[3].dest = 48'hFFFFFFFFFFFF; vecs[3].src = 48'h665544332211;
                    vecs[3].udp = 64'h1F90_0035_001C_BEEF;
    vecs[4] = base; vecs[4].etype = 16'h86DD; vecs[4].e_type = 1'b1;
    vecs[5] = base; vecs[5].n_send = 50; vecs[5].e_len = 1'b1; vecs[5].chk_errs = 1'b0;
    vecs[6] = base; vecs[6].n_send = 88; vecs[6].e_len = 1'b1; vecs[6].chk_errs = 1'b0;
    vecs[7] = base; vecs[7].n_send = 93; vecs[7].e_len = 1'b1;
    vecs[8] = base; vecs[8].pre_len = 3; vecs[8].exp_done = 1'b0;
    vecs[9] = base; vecs[9].pre_len = 4; vecs[9].src = 48'h0F0E0D0C0B0A;
                    vecs[9].udp = 64'h0044_0043_0010_1234;

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 4'h0;
    repeat (3) @(negedge clock);
    chk("reset frame_done", 160'(frame_done), 160'(0));
    chk("reset frame_ok", 160'(frame_ok), 160'(0));
    chk("reset good_cnt", 160'(good_cnt), 160'(0));
    chk("reset bad_cnt", 160'(bad_cnt), 160'(0));
    chk("reset src_mac", 160'(src_mac), 160'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 10; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of the header
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < 30; i++) drive(1'b1, 4'hA);
    #2;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("midrst good_cnt", 160'(good_cnt), 160'(0));
    chk("midrst bad_cnt", 160'(bad_cnt), 160'(0));
    chk("midrst frame_ok", 160'(frame_ok), 160'(0));
    chk("midrst src_mac", 160'(src_mac), 160'(0));
    chk("midrst ip_header", ip_header, 160'(0));
    repeat (2) @(negedge clock);
    reset_n  = 1'b1;
    exp_good = 0;
    exp_bad  = 0;
    last_src = '0;
    last_ip  = '0;
    last_udp = '0;
    @(negedge clock);
    apply(base, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
